fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit_pkg.sv | 23 ++
 rtl/fwd_hazard_unit_match.sv | 25 ++
 rtl/fwd_hazard_unit.sv | 98 +++++++++
 tb/tb_fwd_hazard_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package fwd_hazard_unit_pkg;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_DEPTH  = 2;
  localparam int DEF_SELW   = $clog2(DEF_DEPTH + 1);
  localparam int CNT_W      = 16;

  // fwd_sel value meaning "read the register file"
  localparam int FWD_RF = 0;

  // Control half of a pipeline entry; rd / rs widths follow REG_AW of the instance.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
  } ent_ctl_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// One source register against the post-EX entries; youngest matching stage wins.
module fwd_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SELW   = DEF_SELW
) (
  input  logic [REG_AW-1:0]             src,
  input  logic                          ex_valid,
  input  logic [DEPTH-1:0]              wr,
  input  logic [DEPTH-1:0][REG_AW-1:0]  rd,
  output logic [SELW-1:0]               sel
);

  // index k holds stage k+1; walk oldest to youngest so the youngest hit overrides
  always_comb begin
    sel = SELW'(FWD_RF);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (wr[k] && rd[k] == src) sel = SELW'(DEPTH - k);
    end
    if (!ex_valid || src == '0) sel = SELW'(FWD_RF);
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-stage load-use stall and EX operand forwarding selects for an in-order pipe.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter  int REG_AW   = DEF_REG_AW,
  parameter  int NSRC     = 2,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int LOAD_LAT = 1,
  localparam int SELW     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NSRC*REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     flush,
  output logic                     stall,
  output logic [NSRC*SELW-1:0]     fwd_sel,
  output logic [CNT_W-1:0]         stall_cnt
);

  ent_ctl_t [DEPTH:0]              ctl;
  logic [DEPTH:0][REG_AW-1:0]      rd;
  logic [NSRC-1:0][REG_AW-1:0]     ex_rs;
  logic [NSRC-1:0][REG_AW-1:0]     id_src;
  logic [NSRC-1:0]                 src_hit;
  logic [DEPTH-1:0]                wr_dn;
  logic [DEPTH:0]                  mr_all;
  logic [NSRC-1:0][SELW-1:0]       sel;
  logic                            id_take;
  logic                            unused_mr;

  assign id_src = id_rs;

  // load-use: a decode source hits a load that is still short of LOAD_LAT
  always_comb begin
    src_hit = '0;
    for (int j = 0; j < NSRC; j++) begin
      for (int k = 0; k < LOAD_LAT; k++) begin
        if (ctl[k].valid && ctl[k].regwrite && ctl[k].memread &&
            rd[k] == id_src[j] && id_src[j] != '0)
          src_hit[j] = 1'b1;
      end
    end
  end

  assign stall   = id_valid && !flush && (|src_hit);
  assign id_take = id_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl       <= '0;
      stall_cnt <= '0;
    end else begin
      ctl[0] <= '{valid: id_take, regwrite: id_regwrite, memread: id_memread};
      for (int k = 1; k <= DEPTH; k++) ctl[k] <= ctl[k-1];
      if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // datapath fields are only meaningful under ctl.valid, so they carry no reset
  always_ff @(posedge clk) begin
    rd[0] <= id_rd;
    ex_rs <= id_src;
    for (int k = 1; k <= DEPTH; k++) rd[k] <= rd[k-1];
  end

  always_comb begin
    wr_dn  = '0;
    mr_all = '0;
    for (int k = 0; k <= DEPTH; k++) begin
      mr_all[k] = ctl[k].memread;
      if (k >= 1) wr_dn[k-1] = ctl[k].valid && ctl[k].regwrite;
    end
  end

  // memread past LOAD_LAT is carried for uniformity but never consulted
  assign unused_mr = ^mr_all;

  for (genvar j = 0; j < NSRC; j++) begin : g_src
    fwd_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SELW   (SELW)
    ) u_match (
      .src      (ex_rs[j]),
      .ex_valid (ctl[0].valid),
      .wr       (wr_dn),
      .rd       (rd[DEPTH:1]),
      .sel      (sel[j])
    );
  end

  assign fwd_sel = sel;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Three instances (LOAD_LAT 1, LOAD_LAT 2, deep pipe for counter saturation) vs a queue model.
module tb_fwd_hazard_unit;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst [N];
  logic        idv [N];
  logic        rw  [N];
  logic        mr  [N];
  logic        fl  [N];
  logic [9:0]  rs  [N];
  logic [4:0]  rd  [N];
  logic        stl [N];
  logic [15:0] cnt [N];
  logic [3:0]  fs0, fs1;
  logic [9:0]  fs2;

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .NSRC(2), .DEPTH(2), .LOAD_LAT(1)) u0 (
    .clk(clk), .reset(rst[0]), .id_valid(idv[0]), .id_rs(rs[0]), .id_rd(rd[0]),
    .id_regwrite(rw[0]), .id_memread(mr[0]), .flush(fl[0]),
    .stall(stl[0]), .fwd_sel(fs0), .stall_cnt(cnt[0]));

  fwd_hazard_unit #(.REG_AW(5), .NSRC(2), .DEPTH(2), .LOAD_LAT(2)) u1 (
    .clk(clk), .reset(rst[1]), .id_valid(idv[1]), .id_rs(rs[1]), .id_rd(rd[1]),
    .id_regwrite(rw[1]), .id_memread(mr[1]), .flush(fl[1]),
    .stall(stl[1]), .fwd_sel(fs1), .stall_cnt(cnt[1]));

  fwd_hazard_unit #(.REG_AW(5), .NSRC(2), .DEPTH(16), .LOAD_LAT(16)) u2 (
    .clk(clk), .reset(rst[2]), .id_valid(idv[2]), .id_rs(rs[2]), .id_rd(rd[2]),
    .id_regwrite(rw[2]), .id_memread(mr[2]), .flush(fl[2]),
    .stall(stl[2]), .fwd_sel(fs2), .stall_cnt(cnt[2]));

  // ---------------- reference model ----------------
  typedef struct {
    bit v, w, m;
    int d, r0, r1;
  } ins_t;

  ins_t hist [N][$];   // hist[i][k] = instruction k stages past decode (0 = EX)
  int   mcnt [N];

  function automatic int dep(input int i);
    return (i == 2) ? 16 : 2;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 16;
  endfunction

  function automatic ins_t id_ins(input int i);
    ins_t r;
    r.v = idv[i]; r.w = rw[i]; r.m = mr[i];
    r.d = int'(rd[i]); r.r0 = int'(rs[i][4:0]); r.r1 = int'(rs[i][9:5]);
    return r;
  endfunction

  function automatic bit writes(input ins_t e, input int r);
    return e.v && e.w && r != 0 && e.d == r;
  endfunction

  function automatic bit m_stall(input int i);
    ins_t d;
    d = id_ins(i);
    if (!d.v || fl[i]) return 1'b0;
    for (int k = 0; k < lat(i); k++)
      if (hist[i][k].m && (writes(hist[i][k], d.r0) || writes(hist[i][k], d.r1)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_fwd(input int i, input int j);
    ins_t ex;
    int r;
    ex = hist[i][0];
    if (!ex.v) return 0;
    r = (j == 0) ? ex.r0 : ex.r1;
    for (int k = 1; k <= dep(i); k++)
      if (writes(hist[i][k], r)) return dep(i) + 1 - k;
    return 0;
  endfunction

  function automatic logic [31:0] dut_fwd(input int i, input int j);
    case (i)
      0:       return 32'(fs0[j*2 +: 2]);
      1:       return 32'(fs1[j*2 +: 2]);
      default: return 32'(fs2[j*5 +: 5]);
    endcase
  endfunction

  function automatic ins_t bubble();
    ins_t b;
    b.v = 0; b.w = 0; b.m = 0; b.d = 0; b.r0 = 0; b.r1 = 0;
    return b;
  endfunction

  task automatic clear_hist(input int i);
    hist[i].delete();
    for (int k = 0; k <= dep(i); k++) hist[i].push_back(bubble());
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      ins_t nx;
      bit   s;
      s    = m_stall(i);
      nx   = id_ins(i);
      nx.v = idv[i] && !s && !fl[i];
      if (rst[i]) begin
        clear_hist(i);
        mcnt[i] = 0;
      end else begin
        hist[i].push_front(nx);
        void'(hist[i].pop_back());
        if (s && mcnt[i] < 65535) mcnt[i]++;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL u%0d %s: got %0h expected %0h at %0t", i, nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < N; i++) begin
        chk(i, "stall",  32'(stl[i]), 32'(m_stall(i)));
        chk(i, "fwd0",   dut_fwd(i, 0), 32'(m_fwd(i, 0)));
        chk(i, "fwd1",   dut_fwd(i, 1), 32'(m_fwd(i, 1)));
        chk(i, "cnt",    32'(cnt[i]), 32'(mcnt[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input int i, input bit v, input int r0, input int r1,
                     input int d, input bit w, input bit m);
    idv[i] = v; rs[i] = {5'(r1), 5'(r0)}; rd[i] = 5'(d);
    rw[i] = w; mr[i] = m; fl[i] = 1'b0;
  endtask

  task automatic idle(input int i);
    put(i, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // holds the current decode instruction until it stops stalling; returns stall cycles seen
  task automatic count_stalls(input int i, output int n);
    n = 0;
    while (stl[i] === 1'b1 && n < 40) begin
      n++;
      tick();
      #1;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      idle(i);
      clear_hist(i);
      mcnt[i] = 0;
    end
    tick(); tick();
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    armed = 1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk(i, "rst_stall", 32'(stl[i]), 0);
      chk(i, "rst_fwd0",  dut_fwd(i, 0), 0);
      chk(i, "rst_fwd1",  dut_fwd(i, 1), 0);
      chk(i, "rst_cnt",   32'(cnt[i]), 0);
    end

    fork
      begin : main_lanes
        // ALU chain: add r3 ; sub r6 = r3 - r4
        put(0, 1, 1, 2, 3, 1, 0); tick();
        put(0, 1, 3, 4, 6, 1, 0); #1;
        chk(0, "alu_stall", 32'(stl[0]), 0);
        tick(); idle(0); #1;
        chk(0, "alu_fwd0", dut_fwd(0, 0), 2);
        chk(0, "alu_fwd1", dut_fwd(0, 1), 0);

        // distance 2, consumer in rt slot
        put(0, 1, 1, 2, 3, 1, 0);  tick();
        put(0, 1, 9, 10, 8, 1, 0); tick();
        put(0, 1, 1, 3, 11, 1, 0); tick();
        idle(0); #1;
        chk(0, "dist2_fwd1", dut_fwd(0, 1), 1);
        chk(0, "dist2_fwd0", dut_fwd(0, 0), 0);

        // double hit on r5, then the same shape with rd = 0
        put(0, 1, 1, 2, 5, 1, 0); tick();
        put(0, 1, 1, 2, 5, 1, 0); tick();
        put(0, 1, 5, 0, 12, 1, 0); tick();
        idle(0); #1;
        chk(0, "dbl_fwd0", dut_fwd(0, 0), 2);
        put(0, 1, 1, 2, 0, 1, 0); tick(); tick();
        put(0, 1, 0, 0, 13, 1, 0); tick();
        idle(0); #1;
        chk(0, "r0_fwd0", dut_fwd(0, 0), 0);
        chk(0, "r0_fwd1", dut_fwd(0, 1), 0);

        // load-use, LOAD_LAT = 1
        put(0, 1, 1, 2, 7, 1, 1); tick();
        put(0, 1, 7, 2, 9, 1, 0); #1;
        chk(0, "lu1_stall", 32'(stl[0]), 1);
        count_stalls(0, n);
        chk(0, "lu1_ncyc",   32'(n), 1);
        chk(0, "lu1_bubble", dut_fwd(0, 0), 0);
        chk(0, "lu1_cnt",    32'(cnt[0]), 1);
        tick(); idle(0); #1;
        chk(0, "lu1_fwd0", dut_fwd(0, 0), 1);

        // load-use, LOAD_LAT = 2
        put(1, 1, 1, 2, 7, 1, 1); tick();
        put(1, 1, 7, 2, 9, 1, 0); #1;
        count_stalls(1, n);
        chk(1, "lu2_ncyc", 32'(n), 2);
        chk(1, "lu2_cnt",  32'(cnt[1]), 2);
        tick(); idle(1); #1;
        chk(1, "lu2_fwd0", dut_fwd(1, 0), 0);

        // flush beats stall
        put(0, 1, 1, 2, 7, 1, 1); tick();
        put(0, 1, 7, 2, 9, 1, 0); #1;
        chk(0, "fl_pre_stall", 32'(stl[0]), 1);
        fl[0] = 1'b1; #1;
        chk(0, "fl_stall", 32'(stl[0]), 0);
        tick(); idle(0); #1;
        chk(0, "fl_bubble", dut_fwd(0, 0), 0);
        chk(0, "fl_cnt",    32'(cnt[0]), 1);

        // reset in the middle of a two-cycle stall
        put(1, 1, 1, 2, 7, 1, 1); tick();
        put(1, 1, 7, 2, 9, 1, 0); tick(); #1;
        chk(1, "rs_mid_stall", 32'(stl[1]), 1);
        chk(1, "rs_mid_cnt",   32'(cnt[1]), 3);
        rst[1] = 1'b1; tick(); #1;
        chk(1, "rs_stall", 32'(stl[1]), 0);
        chk(1, "rs_fwd0",  dut_fwd(1, 0), 0);
        chk(1, "rs_fwd1",  dut_fwd(1, 1), 0);
        chk(1, "rs_cnt",   32'(cnt[1]), 0);
        rst[1] = 1'b0; tick(); #1;
        chk(1, "rs_no_resume", 32'(stl[1]), 0);
        idle(1);

        // random traffic on the two shallow instances
        for (int c = 0; c < 3000; c++) begin
          for (int i = 0; i < 2; i++) begin
            idv[i] = ($urandom_range(0, 3) != 0);
            rs[i]  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rd[i]  = 5'($urandom_range(0, 7));
            rw[i]  = ($urandom_range(0, 3) != 0);
            mr[i]  = ($urandom_range(0, 2) == 0);
            fl[i]  = ($urandom_range(0, 9) == 0);
            rst[i] = ($urandom_range(0, 199) == 0);
          end
          tick();
        end
        for (int i = 0; i < 2; i++) begin
          rst[i] = 1'b0;
          idle(i);
        end
      end

      begin : sat_lane
        int s;
        s = 0;
        // a load that consumes its own previous result stalls 16 of every 17 cycles
        put(2, 1, 7, 0, 7, 1, 1);
        for (int c = 0; c < 80000 && s < 70000; c++) begin
          #1;
          if (stl[2] === 1'b1) s++;
          tick();
        end
        chk(2, "sat_stalls", 32'(s), 70000);
        chk(2, "sat_cnt",    32'(cnt[2]), 32'hFFFF);
        idle(2);
      end
    join

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
